// File: rtl/msfsm_mealy_place_engine.sv
// ---------------------------------------------------------------------------
// msfsm_mealy_place_engine
//
// One component FSM of a multi-state-machine decomposition, built as a
// parametrised Mealy place/transition engine. The net structure (source and
// destination place of every transition, which transitions are output
// transitions, which input transitions need a barrier grant) comes entirely
// from parameter tables. The state is one-hot over places.
//
// Each cycle the lowest-index enabled transition fires. Its fire strobe and,
// for output transitions, its Mealy output pulse appear combinationally in
// the same cycle. On the clock edge the state moves to the destination
// place. A state found not one-hot fires nothing. It is forced back to
// INIT_PLACE on the next edge and raises a sticky illegal flag.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset
//   en      in   step enable (0 = stall, nothing fires, state holds)
//   in_sig  in   [NUM_TRANS]   trigger per transition (input transitions only)
//   tb      in   [NUM_TRANS]   transition-barrier grant per transition
//   out     out  [NUM_OUT]     Mealy output pulses (combinational)
//   place   out  [NUM_PLACES]  current one-hot state, fed to sibling FSMs
//   fire    out  [NUM_TRANS]   one-hot strobe of the transition firing now
//   illegal out  sticky flag, set once a non-one-hot state was seen
// ---------------------------------------------------------------------------
module msfsm_mealy_place_engine #(
  parameter int NUM_PLACES = 4,
  parameter int NUM_TRANS  = 5,
  parameter int NUM_OUT    = 2,
  parameter int PW         = $clog2(NUM_PLACES),
  parameter int OW         = ($clog2(NUM_OUT) > 0) ? $clog2(NUM_OUT) : 1,
  parameter int INIT_PLACE = 0,
  parameter logic [NUM_TRANS*PW-1:0] SRC_PLACE   = 10'h394,
  parameter logic [NUM_TRANS*PW-1:0] DST_PLACE   = 10'h039,
  parameter logic [NUM_TRANS-1:0]    IS_OUT_MASK = 5'b11000,
  parameter logic [NUM_TRANS*OW-1:0] OUT_IDX     = 5'b10000,
  parameter logic [NUM_TRANS-1:0]    TB_MASK     = 5'b00110
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_TRANS-1:0]  in_sig,
  input  logic [NUM_TRANS-1:0]  tb,
  output logic [NUM_OUT-1:0]    out,
  output logic [NUM_PLACES-1:0] place,
  output logic [NUM_TRANS-1:0]  fire,
  output logic                  illegal
);

  localparam logic [NUM_PLACES-1:0] INIT_VEC =
    {{(NUM_PLACES-1){1'b0}}, 1'b1} << INIT_PLACE;

  // Table sanity checks at elaboration time.
  if (INIT_PLACE >= NUM_PLACES) begin : g_bad_init
    $error("INIT_PLACE %0d out of range", INIT_PLACE);
  end

  for (genvar g = 0; g < NUM_TRANS; g++) begin : g_check
    if (int'(SRC_PLACE[g*PW +: PW]) >= NUM_PLACES) begin : g_bad_src
      $error("SRC_PLACE field %0d out of range", g);
    end
    if (int'(DST_PLACE[g*PW +: PW]) >= NUM_PLACES) begin : g_bad_dst
      $error("DST_PLACE field %0d out of range", g);
    end
    if (IS_OUT_MASK[g] && (int'(OUT_IDX[g*OW +: OW]) >= NUM_OUT)) begin : g_bad_out
      $error("OUT_IDX field %0d out of range", g);
    end
  end

  logic [NUM_PLACES-1:0] state_q, state_d;
  logic                  illegal_q, illegal_d;

  logic                  state_legal;
  logic [NUM_TRANS-1:0]  guard;
  logic [NUM_TRANS-1:0]  enabled;
  logic                  found;
  logic [PW-1:0]         src_idx;
  logic [PW-1:0]         dst_idx;
  logic [OW-1:0]         out_idx;

  // Guards as whole-vector expressions: output transitions look only at the
  // barrier grant; input transitions need their trigger and, where masked,
  // the barrier grant as well.
  always_comb begin
    guard = (IS_OUT_MASK & tb) | (~IS_OUT_MASK & in_sig & (~TB_MASK | tb));
  end

  // Enabled set. Reset and a non-one-hot state both suppress every
  // transition so fire/out drop combinationally.
  always_comb begin
    state_legal = $onehot(state_q);
    enabled     = '0;
    src_idx     = '0;
    for (int t = 0; t < NUM_TRANS; t++) begin
      src_idx    = SRC_PLACE[t*PW +: PW];
      enabled[t] = en & state_q[src_idx] & guard[t] & state_legal & ~reset;
    end
  end

  // Priority pick (lowest index wins), Mealy outputs and next state.
  always_comb begin
    fire      = '0;
    out       = '0;
    found     = 1'b0;
    dst_idx   = '0;
    out_idx   = '0;
    state_d   = state_q;
    illegal_d = illegal_q;

    for (int t = 0; t < NUM_TRANS; t++) begin
      if (enabled[t] && !found) begin
        found   = 1'b1;
        fire[t] = 1'b1;
        dst_idx = DST_PLACE[t*PW +: PW];
        if (IS_OUT_MASK[t]) begin
          out_idx      = OUT_IDX[t*OW +: OW];
          out[out_idx] = 1'b1;
        end
      end
    end

    if (!state_legal) begin
      // Recovery happens on the next edge regardless of en.
      state_d   = INIT_VEC;
      illegal_d = 1'b1;
    end else if (found) begin
      state_d          = '0;
      state_d[dst_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT_VEC;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign place   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_msfsm_mealy_place_engine.sv
// ---------------------------------------------------------------------------
// Testbench for msfsm_mealy_place_engine (default parameters).
// Net: t0 p0->p1, t1 p1->p2 (needs tb), t2 p1->p3 (needs tb),
//      t3 p2->p0 output 0, t4 p3->p0 output 1.
// The reference model tracks the current place as an integer and walks the
// transition list in index order.
// ---------------------------------------------------------------------------
module tb_msfsm_mealy_place_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [4:0] in_sig;
  logic [4:0] tb_s;
  logic [1:0] out;
  logic [3:0] place;
  logic [4:0] fire;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  msfsm_mealy_place_engine dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .in_sig  (in_sig),
    .tb      (tb_s),
    .out     (out),
    .place   (place),
    .fire    (fire),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Reference net description.
  int m_src  [5] = '{0, 1, 1, 2, 3};
  int m_dst  [5] = '{1, 2, 3, 0, 0};
  bit m_isout[5] = '{0, 0, 0, 1, 1};
  int m_oidx [5] = '{0, 0, 0, 0, 1};
  bit m_tbreq[5] = '{0, 1, 1, 0, 0};

  // Reference state.
  int         m_place   = 0;
  bit         m_illegal = 1'b0;
  bit         m_bad     = 1'b0;
  logic [3:0] m_bad_vec = 4'b0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // What the net should do this cycle given the current inputs.
  task automatic model_eval(output logic [4:0] efire, output logic [1:0] eout,
                            output int enext);
    bit g;
    efire = '0;
    eout  = '0;
    enext = m_place;
    if (!m_bad && !reset && en) begin
      for (int t = 0; t < 5; t++) begin
        if (m_isout[t]) g = tb_s[t];
        else            g = in_sig[t] && (!m_tbreq[t] || tb_s[t]);
        if (efire == 5'd0 && m_place == m_src[t] && g) begin
          efire[t] = 1'b1;
          if (m_isout[t]) eout[m_oidx[t]] = 1'b1;
          enext = m_dst[t];
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] ef;
    logic [1:0] eo;
    int         en_x;
    logic [3:0] ep;
    model_eval(ef, eo, en_x);
    ep = m_bad ? m_bad_vec : (4'b0001 << m_place);
    check({tag, ".place"},   place,   ep);
    check({tag, ".fire"},    fire,    ef);
    check({tag, ".out"},     out,     eo);
    check({tag, ".illegal"}, illegal, m_illegal);
  endtask

  // One clock cycle: inputs driven just after an edge, outputs checked
  // mid-cycle, model advanced across the edge.
  task automatic cyc(input logic e, input logic [4:0] i, input logic [4:0] b,
                     input string tag);
    logic [4:0] ef;
    logic [1:0] eo;
    int         nx;
    en = e; in_sig = i; tb_s = b;
    #2;
    check_all(tag);
    model_eval(ef, eo, nx);
    @(posedge clk);
    #1;
    if (m_bad) begin
      m_place   = 0;
      m_illegal = 1'b1;
      m_bad     = 1'b0;
    end else begin
      m_place = nx;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; in_sig = '0; tb_s = '0;
    m_place = 0; m_illegal = 1'b0; m_bad = 1'b0;
    #2;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Idle after reset.
    for (int k = 0; k < 10; k++) cyc(1'b1, 5'b00000, 5'b00000, "idle");
    check("idle_place_const", place, 4'b0001);

    // t0, then t1 blocked by its barrier, then granted.
    cyc(1'b1, 5'b00001, 5'b00000, "t0");
    check("t0_next_place", place, 4'b0010);
    cyc(1'b1, 5'b00010, 5'b00000, "t1_blocked");
    check("t1_blocked_place", place, 4'b0010);
    cyc(1'b1, 5'b00010, 5'b00010, "t1_go");
    check("t1_next_place", place, 4'b0100);

    // Output transition t3 from p2.
    en = 1'b1; in_sig = '0; tb_s = 5'b01000;
    #2;
    check("t3_out_same_cycle", out, 2'b01);
    check("t3_fire_same_cycle", fire, 5'b01000);
    #1;
    cyc(1'b1, 5'b00000, 5'b01000, "t3");
    check("t3_next_place", place, 4'b0001);

    // Priority: t1 and t2 both enabled from p1, t1 wins.
    cyc(1'b1, 5'b00001, 5'b00000, "t0b");
    en = 1'b1; in_sig = 5'b00110; tb_s = 5'b00110;
    #2;
    check("prio_fire", fire, 5'b00010);
    #1;
    cyc(1'b1, 5'b00110, 5'b00110, "prio");
    check("prio_next_place", place, 4'b0100);
    cyc(1'b1, 5'b00000, 5'b01000, "t3b");

    // Through p3 to output 1.
    cyc(1'b1, 5'b00001, 5'b00000, "t0c");
    cyc(1'b1, 5'b00100, 5'b00100, "t2");
    check("t2_next_place", place, 4'b1000);
    en = 1'b1; in_sig = '0; tb_s = 5'b10000;
    #2;
    check("t4_out_same_cycle", out, 2'b10);
    #1;
    cyc(1'b1, 5'b00000, 5'b10000, "t4");

    // Stall with t0 guard true, then release.
    for (int k = 0; k < 5; k++) cyc(1'b0, 5'b00001, 5'b00000, "stall");
    check("stall_place", place, 4'b0001);
    cyc(1'b1, 5'b00001, 5'b00000, "unstall");
    check("unstall_place", place, 4'b0010);

    // Randomized run against the model.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), "rand");
    end

    // Illegal state: two places set; t1/t2 guards true must not fire.
    force dut.state_q = 4'b0110;
    m_bad = 1'b1; m_bad_vec = 4'b0110;
    #1;
    release dut.state_q;
    en = 1'b1; in_sig = 5'b00110; tb_s = 5'b00110;
    #1;
    check("bad_out", out, 2'b00);
    check("bad_fire", fire, 5'b00000);
    cyc(1'b1, 5'b00110, 5'b00110, "bad");
    check("recover_place", place, 4'b0001);
    check("recover_illegal", illegal, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "sticky");
    end

    // Reset asserted mid-cycle while a transition is firing.
    do_reset();
    check("reset_clears_illegal", illegal, 1'b0);
    cyc(1'b1, 5'b00001, 5'b00000, "pre_mid");
    en = 1'b1; in_sig = 5'b00010; tb_s = 5'b00010;
    #2;
    check("mid_fire_before", fire, 5'b00010);
    reset = 1'b1;
    #1;
    check("mid_reset_place", place, 4'b0001);
    check("mid_reset_fire", fire, 5'b00000);
    check("mid_reset_out", out, 2'b00);
    m_place = 0; m_illegal = 1'b0; m_bad = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), "post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msfsm_mealy_place_engine.md
Name: msfsm_mealy_place_engine

Overview:
- Generic parametrised synchronous Mealy component for one FSM of a multi-state-machine (MSFSM) decomposition.
- The place/transition structure is set by parameter tables, not hand-written case statements.
- State is one-hot over places. Transitions are guarded by input signals and by transition-barrier (TB) handshakes from sibling FSMs.
- Adds a stall enable, priority resolution, per-transition fire strobes and illegal-state recovery.
- Sits alongside sibling FSM instances. The place outputs feed the siblings' TB inputs.

Parameters:
- NUM_PLACES, 4, number of places (one-hot state width), >=2.
- NUM_TRANS, 5, number of transitions, >=1.
- NUM_OUT, 2, number of Mealy outputs, >=1.
- PW, $clog2(NUM_PLACES), place index width (derived).
- OW, ($clog2(NUM_OUT) > 0 ? $clog2(NUM_OUT) : 1), output index width (derived).
- INIT_PLACE, 0, place index loaded on reset and on illegal-state recovery.
- SRC_PLACE, 10'h394, packed NUM_TRANS*PW; field t = source place of transition t (t0 in LSBs).
- DST_PLACE, 10'h039, packed NUM_TRANS*PW; destination place of transition t.
- IS_OUT_MASK, 5'b11000, bit t=1: transition t is an output transition.
- OUT_IDX, 5'b10000, packed NUM_TRANS*OW; output index driven by output transition t.
- TB_MASK, 5'b00110, bit t=1: input transition t also requires tb[t].

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  step enable; 0 = stall.
- in_sig  in  NUM_TRANS  trigger input per transition (ignored for output transitions).
- tb  in  NUM_TRANS  transition-barrier grant per transition.
- out  out  NUM_OUT  Mealy output pulses.
- place  out  NUM_PLACES  one-hot current place (the sync outputs to siblings).
- fire  out  NUM_TRANS  one-hot strobe of the transition firing this cycle.
- illegal  out  1  sticky flag: state was found not one-hot.

Behaviour:
- Reset (async assert, sync to clk on release):
  - state = 1<<INIT_PLACE.
  - illegal = 0.
  - place mirrors state.
  - fire = 0 and out = 0 while reset is high.
- Guard for input transition t (IS_OUT_MASK[t]=0): in_sig[t] & (TB_MASK[t] ? tb[t] : 1).
- Guard for output transition t (IS_OUT_MASK[t]=1): tb[t]. in_sig[t] is ignored.
- Enabled(t) = en & state[SRC_PLACE[t]] & guard(t) & state_legal.
- Priority: the lowest-index enabled transition fires; at most one per cycle. fire is its one-hot vector, all zeros if none is enabled.
- Mealy outputs are combinational in the same cycle:
  - out[k] = 1 iff the firing transition t is an output transition with OUT_IDX[t]==k.
  - Otherwise out = 0.
  - No register in the out path; latency 0 from tb to out.
- Next state: on the clk edge, if a transition t fires, state <= 1<<DST_PLACE[t]. Otherwise state holds.
- Self-loop (SRC==DST): fires normally; fire and out pulse every cycle the guard holds.
- en=0: fire=0, out=0, state holds. Inputs are not latched; guards are re-evaluated when en returns.
- Illegal state: if state is not one-hot (zero or more than one bit set) at an edge:
  - No transition fires; out=0 and fire=0 that cycle.
  - Next edge: state <= 1<<INIT_PLACE and illegal <= 1.
  - illegal stays 1 until reset. place shows the raw state during the bad cycle.
- Reset asserted mid-operation: immediate return to INIT_PLACE. out and fire drop combinationally.
- Elaboration checks: a field >= NUM_PLACES, or OUT_IDX >= NUM_OUT on an output transition, raises a $error.

Test Plan (default parameters; places p0..p3, t0 p0->p1, t1 p1->p2, t2 p1->p3, t3 p2->p0/out0, t4 p3->p0/out1):
- Reset then release, en=1, all inputs 0: place=4'b0001, out=0, fire=0, illegal=0 for 10 cycles.
- in_sig[0]=1 one cycle: fire=5'b00001 that cycle; place=4'b0010 next cycle. Then in_sig[1]=1 with tb[1]=0: no move; set tb[1]=1: place=4'b0100.
- In p1, in_sig[1]=in_sig[2]=tb[1]=tb[2]=1: t1 wins. fire=5'b00010, next place=4'b0100; t2 never fires.
- In p2, tb[3]=1: out=2'b01 and fire=5'b01000 in the same cycle, then place=4'b0001. Via p3 with tb[4]=1: out=2'b10.
- en=0 with t0 guard true for 5 cycles: place stays 4'b0001, fire=0. en=1: fires on the first enabled edge.
- Force state=4'b0110: out=0 that cycle, then place=4'b0001 and illegal=1; illegal stays 1 until reset. Assert reset mid-transition: place=4'b0001 with no clk edge required.
